// File: rtl/id_hazard_sched.sv
// id_hazard_sched: decode-stage issue scheduler with a 64-entry register write scoreboard.
// Holds instructions whose sources or destination are pending, caps writes in flight, supports drain.
module id_hazard_sched #(
  parameter int MAX_INFLIGHT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  input  logic        use_rs,
  input  logic        use_rt,
  input  logic        wr_rd,
  input  logic        flush,
  input  logic        wb_valid,
  input  logic [5:0]  wb_rd,
  input  logic        drain_req,
  output logic        issue,
  output logic        stall,
  output logic [3:0]  inflight,
  output logic [63:0] pend,
  output logic        drain_done,
  output logic        err
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] MaxCnt = 4'(MAX_INFLIGHT);

  state_t      state;
  state_t      stateNext;
  logic [5:0]  rd;
  logic [5:0]  rs;
  logic [5:0]  rt;
  logic        hazard;
  logic        full;
  logic        setEn;
  logic        clrEn;
  logic        badWb;
  logic        overflow;
  logic        underflow;
  logic [63:0] pendNext;
  logic [3:0]  inflightNext;
  logic        unusedInst;

  assign rd = inst[27:22];
  assign rs = inst[21:16];
  assign rt = inst[15:10];
  assign unusedInst = ^{inst[31:28], inst[9:0]};

  // Hazards look only at registered pend; a same-cycle write-back does not release.
  always_comb begin
    hazard = (use_rs & pend[rs]) | (use_rt & pend[rt]) | (wr_rd & pend[rd]);
    full   = wr_rd & (inflight == MaxCnt);
    issue  = inst_valid & ~flush & ~hazard & ~full & (state == RUN);
    stall  = inst_valid & ~issue & ~flush;
  end

  always_comb begin
    setEn        = issue & wr_rd;
    clrEn        = wb_valid & pend[wb_rd];
    badWb        = wb_valid & ~pend[wb_rd];
    pendNext     = pend;
    inflightNext = inflight;
    overflow     = 1'b0;
    underflow    = 1'b0;
    if (setEn) pendNext[rd] = 1'b1;
    if (clrEn) pendNext[wb_rd] = 1'b0;
    // Set and clear in one cycle always hit different bits, so the count nets out.
    if (setEn && !clrEn) begin
      if (inflight == 4'hF) overflow = 1'b1;
      else                  inflightNext = inflight + 4'd1;
    end else if (clrEn && !setEn) begin
      if (inflight == 4'd0) underflow = 1'b1;
      else                  inflightNext = inflight - 4'd1;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (drain_req) stateNext = DRAIN;
      DRAIN:   if (inflight == 4'd0) stateNext = DONE;
      DONE:    if (!drain_req) stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      pend       <= '0;
      inflight   <= '0;
      drain_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= stateNext;
      pend       <= pendNext;
      inflight   <= inflightNext;
      // Pulses only on the DRAIN->DONE edge, so a lingering DONE keeps it low.
      drain_done <= (state == DRAIN) && (inflight == 4'd0);
      if (badWb || overflow || underflow) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_hazard_sched.sv
// Bench for id_hazard_sched: directed vector table, async reset mid-drain, and random traffic
// checked against a model that keeps the set of pending registers and derives the count from it.
module tb_id_hazard_sched;

  localparam int MaxInflight = 3;
  localparam int ModeRun     = 0;
  localparam int ModeDrain   = 1;
  localparam int ModeDone    = 2;

  logic        clk;
  logic        rst_n;
  logic        inst_valid;
  logic [31:0] inst;
  logic        use_rs;
  logic        use_rt;
  logic        wr_rd;
  logic        flush;
  logic        wb_valid;
  logic [5:0]  wb_rd;
  logic        drain_req;
  logic        issue;
  logic        stall;
  logic [3:0]  inflight;
  logic [63:0] pend;
  logic        drain_done;
  logic        err;

  id_hazard_sched #(.MAX_INFLIGHT(MaxInflight)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst(inst),
    .use_rs(use_rs), .use_rt(use_rt), .wr_rd(wr_rd), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .drain_req(drain_req),
    .issue(issue), .stall(stall), .inflight(inflight), .pend(pend),
    .drain_done(drain_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int instValid; int rd; int rs; int rt; int useRs; int useRt; int wrRd; int fl;
    int wbValid; int wbRd; int drain; int expIssue; int expStall; int expInflight;
  } vec_t;

  int  testsRun = 0;
  int  testsFailed = 0;
  bit  refPend[64];
  bit  refErr;
  bit  refDone;
  int  refMode;
  bit  lastStall;
  bit  lastIssue;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic int pendingCount();
    int n = 0;
    for (int i = 0; i < 64; i++) if (refPend[i]) n++;
    return n;
  endfunction

  function automatic logic [63:0] pendVector();
    logic [63:0] v = '0;
    for (int i = 0; i < 64; i++) v[i] = refPend[i];
    return v;
  endfunction

  function automatic bit modelIssue();
    bit hz;
    bit fullNow;
    hz = (use_rs && refPend[inst[21:16]]) || (use_rt && refPend[inst[15:10]]) ||
         (wr_rd && refPend[inst[27:22]]);
    fullNow = wr_rd && (pendingCount() == MaxInflight);
    return inst_valid && !flush && !hz && !fullNow && (refMode == ModeRun);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 64; i++) refPend[i] = 1'b0;
    refErr = 1'b0;
    refDone = 1'b0;
    refMode = ModeRun;
  endtask

  task automatic modelUpdate(input bit mi);
    int cnt = pendingCount();
    refDone = (refMode == ModeDrain) && (cnt == 0);
    case (refMode)
      ModeRun:   if (drain_req) refMode = ModeDrain;
      ModeDrain: if (cnt == 0) refMode = ModeDone;
      default:   if (!drain_req) refMode = ModeRun;
    endcase
    if (wb_valid) begin
      if (refPend[wb_rd]) refPend[wb_rd] = 1'b0;
      else                refErr = 1'b1;
    end
    if (mi && wr_rd) refPend[inst[27:22]] = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    inst_valid      = 1'(v.instValid);
    inst            = $urandom;
    inst[27:22]     = 6'(v.rd);
    inst[21:16]     = 6'(v.rs);
    inst[15:10]     = 6'(v.rt);
    use_rs          = 1'(v.useRs);
    use_rt          = 1'(v.useRt);
    wr_rd           = 1'(v.wrRd);
    flush           = 1'(v.fl);
    wb_valid        = 1'(v.wbValid);
    wb_rd           = 6'(v.wbRd);
    drain_req       = 1'(v.drain);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " pend"}, pend, pendVector());
    check({tag, " inflight"}, 64'(inflight), 64'(pendingCount()));
    check({tag, " err"}, 64'(err), 64'(refErr));
    check({tag, " drain_done"}, 64'(drain_done), 64'(refDone));
  endtask

  // Combinational outputs are sampled mid-cycle, registered ones 1 ns after the edge.
  task automatic stepAndCheck(input string tag);
    bit mi;
    bit ms;
    #3;
    mi = modelIssue();
    ms = inst_valid && !mi && !flush;
    check({tag, " issue"}, 64'(issue), 64'(mi));
    check({tag, " stall"}, 64'(stall), 64'(ms));
    lastIssue = mi;
    lastStall = ms;
    @(posedge clk);
    modelUpdate(mi);
    #1;
    checkOutput(tag);
  endtask

  vec_t vecs[23];
  vec_t v;

  initial begin
    // valid rd rs rt useRs useRt wrRd flush wbV wbRd drain | issue stall inflight
    vecs[0]  = '{1, 5, 1, 2, 1,1,1,0, 0,0,0, 1,0,1};
    vecs[1]  = '{1, 0, 5, 0, 1,0,0,0, 0,0,0, 0,1,1};
    vecs[2]  = '{1, 0, 5, 0, 1,0,0,0, 1,5,0, 0,1,0};
    vecs[3]  = '{1, 0, 5, 0, 1,0,0,0, 0,0,0, 1,0,0};
    vecs[4]  = '{1, 1, 0, 0, 0,0,1,0, 0,0,0, 1,0,1};
    vecs[5]  = '{1, 2, 0, 0, 0,0,1,0, 0,0,0, 1,0,2};
    vecs[6]  = '{1, 3, 0, 0, 0,0,1,0, 0,0,0, 1,0,3};
    vecs[7]  = '{1, 4, 0, 0, 0,0,1,0, 0,0,0, 0,1,3};
    vecs[8]  = '{1, 0,10,11, 1,1,0,0, 0,0,0, 1,0,3};
    vecs[9]  = '{1, 4, 0, 0, 0,0,1,0, 1,2,0, 0,1,2};
    vecs[10] = '{1, 4, 0, 0, 0,0,1,0, 0,0,0, 1,0,3};
    vecs[11] = '{0, 0, 0, 0, 0,0,0,0, 1,1,0, 0,0,2};
    vecs[12] = '{1, 7, 0, 0, 0,0,1,0, 1,3,0, 1,0,2};
    vecs[13] = '{0, 0, 0, 0, 0,0,0,0, 1,9,0, 0,0,2};
    vecs[14] = '{1, 0,12,13, 1,1,0,0, 0,0,1, 1,0,2};
    vecs[15] = '{1, 0,12,13, 1,1,0,0, 1,4,1, 0,1,1};
    vecs[16] = '{0, 0, 0, 0, 0,0,0,0, 1,7,1, 0,0,0};
    vecs[17] = '{0, 0, 0, 0, 0,0,0,0, 0,0,1, 0,0,0};
    vecs[18] = '{1, 0,12,13, 1,1,0,0, 0,0,1, 0,1,0};
    vecs[19] = '{1, 0,12,13, 1,1,0,0, 0,0,0, 0,1,0};
    vecs[20] = '{1,20, 0, 0, 0,0,1,0, 0,0,0, 1,0,1};
    vecs[21] = '{1,21, 0, 0, 0,0,1,1, 0,0,0, 0,0,1};
    vecs[22] = '{1,20,20,20, 1,1,1,0, 0,0,0, 0,1,1};

    rst_n = 1'b0;
    v = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    applyStimulus(v);
    modelReset();
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset pend", pend, 64'h0);
    check("reset inflight", 64'(inflight), 64'h0);
    check("reset err", 64'(err), 64'h0);
    check("reset drain_done", 64'(drain_done), 64'h0);

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i]);
      stepAndCheck($sformatf("vec%0d", i));
      check($sformatf("vec%0d table issue", i), 64'(lastIssue), 64'(vecs[i].expIssue));
      check($sformatf("vec%0d table stall", i), 64'(lastStall), 64'(vecs[i].expStall));
      check($sformatf("vec%0d table inflight", i), 64'(inflight), 64'(vecs[i].expInflight));
    end
    check("sticky err after table", 64'(err), 64'h1);

    // Async reset while draining with r20 still pending.
    v = '{0,0,0,0,0,0,0,0,0,0,1,0,0,0};
    applyStimulus(v);
    stepAndCheck("drainEnter");
    stepAndCheck("drainHold");
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    check("async reset pend", pend, 64'h0);
    check("async reset inflight", 64'(inflight), 64'h0);
    check("async reset err", 64'(err), 64'h0);
    drain_req = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    v = '{1,6,0,0,0,0,1,0,0,0,0,0,0,0};
    applyStimulus(v);
    stepAndCheck("postReset");
    check("postReset issue in RUN", 64'(lastIssue), 64'h1);

    lastStall = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!lastStall) begin
        inst_valid  = ($urandom_range(0, 3) != 0);
        inst        = $urandom;
        inst[27:22] = 6'($urandom_range(0, 7));
        inst[21:16] = 6'($urandom_range(0, 7));
        inst[15:10] = 6'($urandom_range(0, 7));
        use_rs      = 1'($urandom_range(0, 1));
        use_rt      = 1'($urandom_range(0, 1));
        wr_rd       = 1'($urandom_range(0, 1));
        flush       = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
      begin
        int q[$];
        for (int r = 0; r < 64; r++) if (refPend[r]) q.push_back(r);
        wb_valid = 1'b0;
        wb_rd    = 6'($urandom_range(0, 63));
        if (q.size() > 0 && $urandom_range(0, 9) < 4) begin
          wb_valid = 1'b1;
          wb_rd    = 6'(q[$urandom_range(0, q.size() - 1)]);
        end else if ($urandom_range(0, 49) == 0) begin
          wb_valid = 1'b1;
        end
      end
      stepAndCheck($sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
